// File: rtl/pm_sensor_quality_if.sv
// PM sensor front-end bus: controller-side stimulus and quality results.
interface pm_sensor_quality_if #(
    parameter int unsigned CNT_W = 20
);
    logic             enable;
    logic             sens_in;
    logic             quality;
    logic [CNT_W-1:0] low_count;
    logic             window_done;
    logic             sens_fault;

    modport master (
        output enable,
        output sens_in,
        input  quality,
        input  low_count,
        input  window_done,
        input  sens_fault
    );

    modport slave (
        input  enable,
        input  sens_in,
        output quality,
        output low_count,
        output window_done,
        output sens_fault
    );
endinterface

// File: rtl/pm_sensor_quality.sv
// PM sensor quality front end: synchronise and deglitch the low-active pulse,
// measure low occupancy over back-to-back windows, apply hysteresis thresholds.
module pm_sensor_quality #(
    parameter int unsigned SAMPLE_DIV   = 5000,
    parameter int unsigned WARMUP_TICKS = 20000,
    parameter int unsigned WINDOW_TICKS = 300000,
    parameter int unsigned FILT_LEN     = 4,
    parameter int unsigned TH_HI        = 30000,
    parameter int unsigned TH_LO        = 15000,
    parameter int unsigned CNT_W        = 20
) (
    input logic              clk,
    input logic              reset,
    pm_sensor_quality_if.slave bus
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [DIV_W-1:0] DivLast  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] WarmLast = CNT_W'(WARMUP_TICKS - 1);
    localparam logic [CNT_W-1:0] WinLast  = CNT_W'(WINDOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ThHi     = CNT_W'(TH_HI);
    localparam logic [CNT_W-1:0] ThLo     = CNT_W'(TH_LO);

    typedef enum logic [1:0] {StIdle, StWarmup, StMeasure, StEval} state_e;

    logic                sync1, sync2;
    logic [DIV_W-1:0]    div_q;
    logic                tick;
    logic [FILT_LEN-1:0] shift_q, shift_d;
    logic                filt_q, filt_d;
    logic                filt_change;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]    low_acc_q, low_acc_d;
    logic [CNT_W-1:0]    low_count_q, low_count_d;
    logic                edge_q, edge_d;
    logic                fault_q, fault_d;
    logic                quality_q, quality_d;
    logic                window_done;

    assign tick        = bus.enable && (div_q == DivLast);
    assign filt_change = (filt_d != filt_q);

    // Two-flop synchroniser; idles high like the sensor line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= bus.sens_in;
            sync2 <= sync1;
        end
    end

    // Sample-tick divider, held cleared while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (!bus.enable || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Deglitch: level flips only when the whole shift register agrees on the new value.
    always_comb begin
        shift_d = shift_q;
        filt_d  = filt_q;
        if (tick) begin
            shift_d = (shift_q << 1) | FILT_LEN'(sync2);
            if ((&shift_d) && !filt_q) begin
                filt_d = 1'b1;
            end else if (!(|shift_d) && filt_q) begin
                filt_d = 1'b0;
            end
        end
    end

    // Filter state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '1;
            filt_q  <= 1'b1;
        end else begin
            shift_q <= shift_d;
            filt_q  <= filt_d;
        end
    end

    // Measurement FSM next state; enable low overrides every state, including EVAL.
    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        low_acc_d   = low_acc_q;
        edge_d      = edge_q;
        low_count_d = low_count_q;
        fault_d     = fault_q;
        quality_d   = quality_q;
        window_done = 1'b0;
        if (!bus.enable) begin
            state_d   = StIdle;
            win_cnt_d = '0;
            low_acc_d = '0;
            edge_d    = 1'b0;
            quality_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d   = StWarmup;
                    win_cnt_d = '0;
                    low_acc_d = '0;
                    edge_d    = 1'b0;
                end
                StWarmup: begin
                    if (tick) begin
                        if (win_cnt_q == WarmLast) begin
                            state_d   = StMeasure;
                            win_cnt_d = '0;
                        end else begin
                            win_cnt_d = win_cnt_q + 1'b1;
                        end
                    end
                end
                StMeasure: begin
                    if (filt_change) begin
                        edge_d = 1'b1;
                    end
                    if (tick) begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        if (!filt_q) begin
                            low_acc_d = low_acc_q + 1'b1;
                        end
                        // The tick that completes the window is counted above.
                        if (win_cnt_q == WinLast) begin
                            state_d = StEval;
                        end
                    end
                end
                StEval: begin
                    window_done = 1'b1;
                    low_count_d = low_acc_q;
                    fault_d     = !edge_q;
                    if (edge_q) begin
                        if (low_acc_q >= ThHi) begin
                            quality_d = 1'b1;
                        end else if (low_acc_q < ThLo) begin
                            quality_d = 1'b0;
                        end
                    end
                    win_cnt_d = '0;
                    low_acc_d = '0;
                    edge_d    = 1'b0;
                    state_d   = StMeasure;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM and measurement registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            win_cnt_q   <= '0;
            low_acc_q   <= '0;
            low_count_q <= '0;
            edge_q      <= 1'b0;
            fault_q     <= 1'b0;
            quality_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            low_acc_q   <= low_acc_d;
            low_count_q <= low_count_d;
            edge_q      <= edge_d;
            fault_q     <= fault_d;
            quality_q   <= quality_d;
        end
    end

    assign bus.quality     = quality_q;
    assign bus.low_count   = low_count_q;
    assign bus.window_done = window_done;
    assign bus.sens_fault  = fault_q;

endmodule
